// File: rtl/de_coder_config_slave.sv
// de_coder_config_slave
//   I2C target for the decoder-configuration write protocol:
//   S, device byte, sub-address high, sub-address low, data bytes..., P.
//   SCL/SDA are oversampled on clk. SDA is only ever pulled low (ACK) and
//   SCL is never driven.
// Ports
//   clk       system clock (>= 8x SCL)
//   reset     asynchronous, active-low
//   SCL       bus clock (input only)
//   SDA       bus data, open-drain (0 or z)
//   wr_valid  1-clk pulse, wr_addr/wr_data hold a completed write
//   wr_addr   16-bit register pointer of that write
//   wr_data   data byte of that write
//   ready     high while idle
//   errory    1-clk pulse, START/STOP arrived with a byte partly shifted
module de_coder_config_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h3B,
    parameter int         SYNC_LEN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCL,
    inout  wire         SDA,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        ready,
    output logic        errory
);

    typedef enum logic [3:0] {
        IDLE, ADDR, A_ACK, SUBH, H_ACK, SUBL, L_ACK, DATA, D_ACK, IGNORE
    } state_t;

    state_t              state, state_n;
    logic [SYNC_LEN-1:0] scl_sync, sda_sync;
    logic                scl_p, sda_p;
    logic [2:0]          bit_cnt;
    logic                pend;      // bit sampled on the current SCL-high phase
    logic [6:0]          shreg;
    logic [7:0]          sub_hi, sub_lo;
    logic [15:0]         ptr;
    logic                ack_on, ack_on_n;
    logic                err_n;

    // Synchroniser; the extra flop after the chain gives the edge reference.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_LEN-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_LEN-2:0], SDA};
            scl_p    <= scl_sync[SYNC_LEN-1];
            sda_p    <= sda_sync[SYNC_LEN-1];
        end
    end

    logic       scl_c, sda_c, rise, fall, start, stop, cond, byte_st, last_bit;
    logic [7:0] byte_val;

    assign scl_c    = scl_sync[SYNC_LEN-1];
    assign sda_c    = sda_sync[SYNC_LEN-1];
    assign rise     = scl_c & ~scl_p;
    assign fall     = ~scl_c & scl_p;
    assign start    = scl_c & scl_p & sda_p & ~sda_c;
    assign stop     = scl_c & scl_p & ~sda_p & sda_c;
    assign cond     = start | stop;
    assign byte_st  = (state == ADDR) || (state == SUBH) ||
                      (state == SUBL) || (state == DATA);
    assign last_bit = rise & byte_st & (bit_cnt == 3'd7);
    assign byte_val = {shreg, sda_c};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ack_on <= 1'b0;
            errory <= 1'b0;
        end else begin
            state  <= state_n;
            ack_on <= ack_on_n;
            errory <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        ack_on_n = ack_on;
        err_n    = 1'b0;
        if (cond) begin
            // A START/STOP always costs one SCL rise that samples a bit which
            // was never completed; only bits whose SCL already fell count.
            err_n    = byte_st && (bit_cnt != {2'b00, pend});
            ack_on_n = 1'b0;
            state_n  = start ? ADDR : IDLE;
        end else begin
            case (state)
                ADDR: if (last_bit)
                          state_n = (byte_val == {DEV_ADDR, 1'b0}) ? A_ACK : IGNORE;
                SUBH: if (last_bit) state_n = H_ACK;
                SUBL: if (last_bit) state_n = L_ACK;
                DATA: if (last_bit) state_n = D_ACK;
                A_ACK, H_ACK, L_ACK, D_ACK: begin
                    // First fall after the 8th bit starts the ACK, next ends it.
                    if (fall) begin
                        if (!ack_on) begin
                            ack_on_n = 1'b1;
                        end else begin
                            ack_on_n = 1'b0;
                            case (state)
                                A_ACK:   state_n = SUBH;
                                H_ACK:   state_n = SUBL;
                                default: state_n = DATA;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            pend     <= 1'b0;
            shreg    <= '0;
            sub_hi   <= '0;
            sub_lo   <= '0;
            ptr      <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (cond) begin
                bit_cnt <= '0;
                pend    <= 1'b0;
            end else begin
                if (fall) pend <= 1'b0;
                if (rise && byte_st) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    pend    <= 1'b1;
                    shreg   <= byte_val[6:0];
                end
                if (last_bit) begin
                    case (state)
                        SUBH: sub_hi <= byte_val;
                        SUBL: sub_lo <= byte_val;
                        DATA: begin
                            wr_valid <= 1'b1;
                            wr_addr  <= ptr;
                            wr_data  <= byte_val;
                            ptr      <= ptr + 16'd1;
                        end
                        default: ;
                    endcase
                end
                if (state == L_ACK && fall && ack_on) ptr <= {sub_hi, sub_lo};
            end
        end
    end

    assign ready = (state == IDLE);

    // Release in the same clk a START/STOP is seen.
    assign SDA = (ack_on && !cond) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_de_coder_config_slave.sv
module tb_de_coder_config_slave;

    localparam int Q = 50;   // quarter SCL period in ns

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda_bus;
    logic        wr_valid, ready, errory;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    int checks = 0;
    int failures = 0;

    int          wv_cnt, err_cnt;
    logic        dut_drove;
    logic [15:0] log_addr [0:7];
    logic [7:0]  log_data [0:7];

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    de_coder_config_slave dut (
        .clk(clk), .reset(reset), .SCL(scl), .SDA(sda_bus),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready), .errory(errory)
    );

    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            if (wv_cnt < 8) begin
                log_addr[wv_cnt] = wr_addr;
                log_data[wv_cnt] = wr_data;
            end
            wv_cnt = wv_cnt + 1;
        end
        if (errory === 1'b1) err_cnt = err_cnt + 1;
        if (!m_low && sda_bus === 1'b0) dut_drove = 1'b1;
    end

    task automatic clr_mon();
        wv_cnt = 0; err_cnt = 0; dut_drove = 1'b0;
    endtask

    task automatic i2c_start();
        scl = 1'b0; #Q; m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        scl = 1'b0; #Q; m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #(4*Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_low = 1'b0; #Q; scl = 1'b1; #Q;
        ack = (sda_bus === 1'b0);
        #Q; scl = 1'b0; #Q;
    endtask

    task automatic test_reset();
        reset = 1'b0; #47;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
        checks++; if (wr_addr !== 16'h0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0000", wr_addr); end
        checks++; if (wr_data !== 8'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        checks++; if (errory !== 1'b0) begin failures++; $display("FAIL reset_errory got=%b exp=0", errory); end
        checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda_bus); end
        reset = 1'b1; #100;
    endtask

    task automatic test_single_write();
        logic a0, a1, a2, a3;
        clr_mon();
        i2c_start();
        send_byte(8'h76, a0); send_byte(8'h40, a1); send_byte(8'h10, a2); send_byte(8'hAB, a3);
        checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin failures++; $display("FAIL single_acks got=%b exp=1111", {a0, a1, a2, a3}); end
        i2c_stop(); #100;
        checks++; if (wv_cnt !== 1) begin failures++; $display("FAIL single_wv_cnt got=%0d exp=1", wv_cnt); end
        checks++; if (log_addr[0] !== 16'h4010) begin failures++; $display("FAIL single_addr got=%h exp=4010", log_addr[0]); end
        checks++; if (log_data[0] !== 8'hAB) begin failures++; $display("FAIL single_data got=%h exp=ab", log_data[0]); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", ready); end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL single_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_nack();
        logic a;
        clr_mon();
        i2c_start();
        send_byte(8'h78, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL nack_ack got=%b exp=0", a); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL nack_ready got=%b exp=0", ready); end
        send_byte(8'h40, a);
        i2c_stop(); #100;
        checks++; if (dut_drove !== 1'b0) begin failures++; $display("FAIL nack_sda_driven got=%b exp=0", dut_drove); end
        checks++; if (wv_cnt !== 0) begin failures++; $display("FAIL nack_wv_cnt got=%0d exp=0", wv_cnt); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL nack_ready_after_p got=%b exp=1", ready); end
    endtask

    task automatic test_wrap();
        logic a;
        clr_mon();
        i2c_start();
        send_byte(8'h76, a); send_byte(8'hFF, a); send_byte(8'hFF, a);
        send_byte(8'h11, a); send_byte(8'h22, a);
        i2c_stop(); #100;
        checks++; if (wv_cnt !== 2) begin failures++; $display("FAIL wrap_wv_cnt got=%0d exp=2", wv_cnt); end
        checks++; if (log_addr[0] !== 16'hFFFF || log_data[0] !== 8'h11) begin failures++; $display("FAIL wrap_w0 got=%h/%h exp=ffff/11", log_addr[0], log_data[0]); end
        checks++; if (log_addr[1] !== 16'h0000 || log_data[1] !== 8'h22) begin failures++; $display("FAIL wrap_w1 got=%h/%h exp=0000/22", log_addr[1], log_data[1]); end
    endtask

    task automatic test_abort();
        logic a;
        clr_mon();
        i2c_start();
        send_byte(8'h76, a); send_byte(8'h40, a); send_byte(8'h10, a);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        i2c_stop(); #100;
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL abort_errory got=%0d exp=1", err_cnt); end
        checks++; if (wv_cnt !== 0) begin failures++; $display("FAIL abort_wv_cnt got=%0d exp=0", wv_cnt); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", ready); end
    endtask

    task automatic test_rstart();
        logic a;
        clr_mon();
        i2c_start();
        send_byte(8'h76, a); send_byte(8'h40, a); send_byte(8'h10, a);
        i2c_start();
        send_byte(8'h76, a); send_byte(8'h40, a); send_byte(8'h20, a); send_byte(8'h55, a);
        i2c_stop(); #100;
        checks++; if (wv_cnt !== 1) begin failures++; $display("FAIL rstart_wv_cnt got=%0d exp=1", wv_cnt); end
        checks++; if (log_addr[0] !== 16'h4020 || log_data[0] !== 8'h55) begin failures++; $display("FAIL rstart_write got=%h/%h exp=4020/55", log_addr[0], log_data[0]); end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL rstart_errory got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_reset_in_ack();
        logic [7:0] b;
        b = 8'h76;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_low = 1'b0; #Q;
        checks++; if (sda_bus !== 1'b0) begin failures++; $display("FAIL rack_sda_held got=%b exp=0", sda_bus); end
        reset = 1'b0; #1;
        checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL rack_sda_release got=%b exp=1", sda_bus); end
        checks++; if (ready !== 1'b1 || wr_valid !== 1'b0 || errory !== 1'b0) begin failures++; $display("FAIL rack_ctl got=%b%b%b exp=100", ready, wr_valid, errory); end
        checks++; if (wr_addr !== 16'h0 || wr_data !== 8'h0) begin failures++; $display("FAIL rack_data got=%h/%h exp=0000/00", wr_addr, wr_data); end
        #40; reset = 1'b1; #40;
        i2c_stop(); #100;
    endtask

    task automatic test_read_nack();
        logic a, a1, a2, a3, a4;
        clr_mon();
        i2c_start();
        send_byte(8'h77, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL read_ack got=%b exp=0", a); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL read_ready got=%b exp=0", ready); end
        i2c_start();
        send_byte(8'h76, a1); send_byte(8'h12, a2); send_byte(8'h34, a3); send_byte(8'h99, a4);
        checks++; if ({a1, a2, a3, a4} !== 4'b1111) begin failures++; $display("FAIL read_then_acks got=%b exp=1111", {a1, a2, a3, a4}); end
        i2c_stop(); #100;
        checks++; if (wv_cnt !== 1 || log_addr[0] !== 16'h1234 || log_data[0] !== 8'h99) begin failures++; $display("FAIL read_then_write got=%0d %h/%h exp=1 1234/99", wv_cnt, log_addr[0], log_data[0]); end
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_single_write();
        test_nack();
        test_wrap();
        test_abort();
        test_rstart();
        test_reset_in_ack();
        test_read_nack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
